// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the MEM stage
// (cpu port, priority) and the external loader/debug port (ext port).
// A starvation counter forces ext in after MAX_WAIT cycles. A burst limit
// hands the memory back to the cpu after MAX_BURST ext grants.
module dmem_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_stall,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             ext_req,
    input  logic             ext_we,
    input  logic [WIDTH-1:0] ext_addr,
    input  logic [WIDTH-1:0] ext_wdata,
    output logic             ext_gnt,
    output logic             ext_rvalid,
    output logic [WIDTH-1:0] ext_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        CPU_OWN = 1'b0,
        EXT_OWN = 1'b1
    } state_t;

    state_t               state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 grant_cpu;
    logic                 grant_ext;
    logic                 wait_full;
    logic                 burst_full;

    assign wait_full  = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign burst_full = (burst_cnt == BURST_W'(MAX_BURST));

    // Grant decision for the current cycle; nothing is granted while in reset.
    always_comb begin
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        if (!rst) begin
            case (state)
                CPU_OWN: begin
                    if (ext_req && wait_full) begin
                        grant_ext = 1'b1;
                    end else if (cpu_req) begin
                        grant_cpu = 1'b1;
                    end else if (ext_req) begin
                        grant_ext = 1'b1;
                    end
                end
                EXT_OWN: begin
                    if (ext_req && !burst_full) begin
                        grant_ext = 1'b1;
                    end else if (cpu_req) begin
                        grant_cpu = 1'b1;
                    end
                end
                default: begin
                    grant_cpu = 1'b0;
                    grant_ext = 1'b0;
                end
            endcase
        end
    end

    // Steer the granted port onto the memory; idle cycles drive zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        cpu_rdata = '0;
        if (grant_ext) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_we    = ext_we;
        end else if (grant_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            cpu_rdata = mem_rdata;
        end
        ext_gnt   = grant_ext;
        cpu_stall = cpu_req && !grant_cpu && !rst;
    end

    // Ownership state, starvation and burst counters, registered ext read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CPU_OWN;
            wait_cnt   <= '0;
            burst_cnt  <= '0;
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= grant_ext && !ext_we;
            if (grant_ext && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
            if (grant_ext) begin
                state     <= EXT_OWN;
                wait_cnt  <= '0;
                burst_cnt <= (state == EXT_OWN) ? BURST_W'(burst_cnt + 1'b1) : BURST_W'(1);
            end else begin
                state     <= CPU_OWN;
                burst_cnt <= '0;
                if (ext_req && !wait_full) begin
                    wait_cnt <= WAIT_W'(wait_cnt + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model built from grant-streak and starvation counts.
module tb_dmem_arbiter;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned MAX_WAIT  = 8;
    localparam int unsigned MAX_BURST = 4;

    logic             clk;
    logic             rst;
    logic             cpu_req, cpu_we;
    logic [WIDTH-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic             cpu_stall;
    logic             ext_req, ext_we, ext_gnt, ext_rvalid;
    logic [WIDTH-1:0] ext_addr, ext_wdata, ext_rdata;
    logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
    logic             mem_we;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {16'hC0DE, 8'h00, a};
    endfunction

    // Memory fixture: combinational read, write on the rising edge.
    logic [31:0] fmem [256];
    bit          fvalid [256];
    assign mem_rdata = fvalid[mem_addr[7:0]] ? fmem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            fmem[mem_addr[7:0]]   <= mem_wdata;
            fvalid[mem_addr[7:0]] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] mmem [256];
    bit          mvalid [256];
    int          m_streak = 0;   // consecutive ext grants ending last cycle
    int          m_starve = 0;   // cycles ext has waited since its last grant
    logic        m_rv = 1'b0;
    logic [31:0] m_rd = '0;
    logic        last_ext_gnt = 1'b0;
    logic        g_ext, g_cpu;
    logic [31:0] e_addr, e_wdata, e_crd;
    logic        e_we;

    function automatic logic [31:0] m_read(input logic [7:0] a);
        return mvalid[a] ? mmem[a] : init_val(a);
    endfunction

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("ext_rvalid", 32'(ext_rvalid), 32'(m_rv));
            check("ext_rdata", ext_rdata, m_rd);
            g_ext = 1'b0;
            g_cpu = 1'b0;
            if (!rst) begin
                if (m_streak > 0)
                    g_ext = ext_req && (m_streak < int'(MAX_BURST));
                else
                    g_ext = ext_req && (m_starve >= int'(MAX_WAIT) || !cpu_req);
                g_cpu = !g_ext && cpu_req;
            end
            e_addr  = g_ext ? ext_addr  : g_cpu ? cpu_addr  : 32'h0;
            e_wdata = g_ext ? ext_wdata : g_cpu ? cpu_wdata : 32'h0;
            e_we    = g_ext ? ext_we    : g_cpu ? cpu_we    : 1'b0;
            e_crd   = g_cpu ? m_read(cpu_addr[7:0]) : 32'h0;
            check("ext_gnt", 32'(ext_gnt), 32'(g_ext));
            check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !g_cpu && !rst));
            check("cpu_rdata", cpu_rdata, e_crd);
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            last_ext_gnt = ext_gnt;
            if (rst) begin
                m_streak = 0;
                m_starve = 0;
                m_rv     = 1'b0;
                m_rd     = '0;
            end else begin
                m_rv = g_ext && !ext_we;
                if (g_ext && !ext_we) m_rd = m_read(ext_addr[7:0]);
                if (g_ext) begin
                    m_streak++;
                    m_starve = 0;
                end else begin
                    m_streak = 0;
                    if (ext_req && m_starve < int'(MAX_WAIT)) m_starve++;
                end
                if (e_we) begin
                    mmem[e_addr[7:0]]   = e_wdata;
                    mvalid[e_addr[7:0]] = 1'b1;
                end
            end
        end
    end

    int         n;
    bit         found;
    int         g;
    logic       pg;
    logic [7:0] hist;
    int         busy;

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7; cpu_wdata = '0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'd1; ext_wdata = '0;
        @(posedge clk); #2;
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_ext_gnt", 32'(ext_gnt), 32'd0);
        check("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1 rst = 1'b0; #1;

        // Starvation: cpu keeps the memory for MAX_WAIT cycles, then ext is forced in.
        n = 0; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (ext_gnt) found = 1'b1;
            else begin
                if (!cpu_stall) n++;
                @(posedge clk); #2;
            end
        end
        check("starve_cpu_grants", 32'(n), 32'd8);
        check("starve_cpu_stall", 32'(cpu_stall), 32'd1);
        check("starve_ext_gnt", 32'(ext_gnt), 32'd1);

        // Burst of 6 ext reads against a busy cpu: 4 ext, 1 cpu, then ext again.
        hist = '0; hist[0] = ext_gnt; g = ext_gnt ? 1 : 0; pg = ext_gnt;
        for (int c = 1; c < 8; c++) begin
            @(posedge clk); #1;
            if (pg) begin
                if (g >= 6) ext_req = 1'b0;
                else ext_addr = 32'(1 + g);
            end
            if (c == 5) cpu_req = 1'b0;
            #1;
            hist[c] = ext_gnt; pg = ext_gnt;
            if (ext_gnt) g++;
            if (c == 1) check("burst_rvalid", 32'(ext_rvalid), 32'd1);
            if (c == 4) check("burst_cpu_slot_stall", 32'(cpu_stall), 32'd0);
        end
        check("burst_pattern", 32'(hist), 32'h6F);

        // cpu store then load of the same address.
        @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'h1234; #1;
        check("cpu_wr_mem_we", 32'(mem_we), 32'd1);
        check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1 cpu_we = 1'b0; #1;
        check("cpu_rd_mem_we", 32'(mem_we), 32'd0);
        check("cpu_rd_data", cpu_rdata, 32'h1234);

        // ext-only write then read.
        @(posedge clk); #1 cpu_req = 1'b0; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'd3; ext_wdata = 32'hDEAD; #1;
        check("ext_wr_gnt", 32'(ext_gnt), 32'd1);
        check("ext_wr_mem_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1 ext_we = 1'b0; #1;
        check("ext_rd_gnt", 32'(ext_gnt), 32'd1);
        @(posedge clk); #1 ext_req = 1'b0; #1;
        check("ext_rd_rvalid", 32'(ext_rvalid), 32'd1);
        check("ext_rd_data", ext_rdata, 32'hDEAD);
        check("ext_rd_cpu_stall", 32'(cpu_stall), 32'd0);

        // Reset in the middle of an ext burst.
        @(posedge clk); #1 ext_req = 1'b1; ext_addr = 32'd8; #1;
        check("mid_gnt0", 32'(ext_gnt), 32'd1);
        @(posedge clk); #1 ext_addr = 32'd9; #1;
        check("mid_gnt1", 32'(ext_gnt), 32'd1);
        @(posedge clk); #1 rst = 1'b1; cpu_req = 1'b1; ext_addr = 32'd10; #1;
        check("mid_rst_gnt", 32'(ext_gnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0; #1;
        check("post_rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("post_rst_ext_gnt", 32'(ext_gnt), 32'd0);
        check("post_rst_rvalid", 32'(ext_rvalid), 32'd0);
        check("post_rst_mem_addr", mem_addr, 32'd5);

        // Randomized traffic; ext holds each request until granted.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst  = ($urandom_range(0, 299) == 0);
            busy = (((i / 500) % 2) == 1) ? 90 : 50;
            cpu_req   = ($urandom_range(0, 99) < busy);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 32'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            if (!ext_req || last_ext_gnt) begin
                ext_req   = ($urandom_range(0, 99) < 60);
                ext_we    = 1'($urandom_range(0, 1));
                ext_addr  = 32'($urandom_range(0, 15));
                ext_wdata = $urandom;
            end
        end
        @(posedge clk); #1 rst = 1'b0; cpu_req = 1'b0; ext_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
